// File: rtl/sop_sweep_ctrl_if.sv
// Handshake/result bundle between the sweep sequencer and its host.
// The combinational unit under test sits on vec_o/f_i.
interface sop_sweep_ctrl_if #(
  parameter int N_INPUTS = 3
);
  localparam int NV = 1 << N_INPUTS;

  logic                start;
  logic                abort;
  logic [NV-1:0]       expected;
  logic [N_INPUTS-1:0] vec_o;
  logic                f_i;
  logic                busy;
  logic                done;
  logic                pass;
  logic [NV-1:0]       truth_table;
  logic [N_INPUTS:0]   mismatch_count;
  logic [N_INPUTS-1:0] first_fail;

  modport master (
    output start, abort, expected, f_i,
    input  vec_o, busy, done, pass, truth_table, mismatch_count, first_fail
  );

  modport slave (
    input  start, abort, expected, f_i,
    output vec_o, busy, done, pass, truth_table, mismatch_count, first_fail
  );
endinterface

// File: rtl/sop_sweep_ctrl.sv
// Exhaustive sweep sequencer for a small combinational block: walks every input
// vector, samples f after a settle time, and compares against an expected truth table.
module sop_sweep_ctrl #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  sop_sweep_ctrl_if.slave  bus
);
  localparam int NV = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] VEC_LAST    = '1;
  localparam logic [N_INPUTS-1:0] VEC_ONE     = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]   MM_ONE      = (N_INPUTS + 1)'(1);
  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NV-1:0]       exp_q, exp_d;
  logic [NV-1:0]       tt_q, tt_d;
  logic [N_INPUTS:0]   mm_q, mm_d;
  logic [N_INPUTS-1:0] ff_q, ff_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  // NOTE: every _d gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        vec_d = '0;
        if (bus.start) begin
          exp_d   = bus.expected;
          tt_d    = '0;
          mm_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.abort) begin
          // Cancel wins over a sample landing on the same edge; partial results stay.
          state_d = IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          tt_d[vec_q] = bus.f_i;
          if (bus.f_i != exp_q[vec_q]) begin
            mm_d = mm_q + MM_ONE;
            if (mm_q == '0) ff_d = vec_q;
          end
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_d == '0);
            vec_d   = '0;
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec_o          = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.truth_table    = tt_q;
  assign bus.mismatch_count = mm_q;
  assign bus.first_fail     = ff_q;
endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Bench for sop_sweep_ctrl: drives a table-defined datapath and compares sweep
// timing and results against a truth-table level model.
module tb_sop_sweep_ctrl;
  localparam int N      = 3;
  localparam int NV     = 1 << N;
  localparam int SETTLE = 1;
  localparam int SWEEP  = (SETTLE + 1) * NV;

  logic clk;
  logic rst_n;
  logic [NV-1:0] f_tab;

  int n_checks = 0;
  int n_fail   = 0;

  sop_sweep_ctrl_if #(.N_INPUTS(N)) bus ();

  sop_sweep_ctrl #(.N_INPUTS(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath stand-in: f for vector i is bit i of f_tab.
  assign bus.f_i = f_tab[bus.vec_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // f = ~x~z | ~y z, with x = bit 2, y = bit 1, z = bit 0.
  function automatic logic [NV-1:0] sop_table();
    logic [NV-1:0] t;
    for (int i = 0; i < NV; i++) begin
      logic x, y, z;
      x = i[2]; y = i[1]; z = i[0];
      t[i] = (!x && !z) || (!y && z);
    end
    return t;
  endfunction

  // Result of a sweep in which the first n_sampled vectors were captured.
  task automatic model(input logic [NV-1:0] exp, input logic [NV-1:0] ftab, input int n_sampled,
                       output logic [NV-1:0] tt, output logic [N:0] mm,
                       output logic [N-1:0] ff, output logic ps);
    int cnt, first;
    cnt = 0; first = 0; tt = '0;
    for (int i = 0; i < n_sampled; i++) begin
      tt[i] = ftab[i];
      if (ftab[i] != exp[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    mm = (N + 1)'(cnt);
    ff = N'(first);
    ps = (n_sampled == NV) && (cnt == 0);
  endtask

  // Starts a sweep and follows it edge by edge; returns the cycle done was seen, or -1.
  task automatic do_sweep(input logic [NV-1:0] exp, input int restart_at, input int abort_at,
                          output int done_cyc);
    done_cyc = -1;
    bus.start = 1'b1;
    bus.expected = exp;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.expected = ~exp;
    for (int k = 0; k <= SWEEP + 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (bus.busy && bus.done) begin
        n_fail++; $display("FAIL busy_done_overlap: cycle %0d busy and done both 1", k);
      end
      if (bus.done && done_cyc < 0) done_cyc = k;
      if (abort_at < 0 && k < SWEEP) begin
        n_checks++;
        if (bus.vec_o !== N'(k / (SETTLE + 1)) || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sequence: cycle %0d got vec=%0d busy=%b, want vec=%0d busy=1",
                   k, bus.vec_o, bus.busy, k / (SETTLE + 1));
        end
      end
      if (abort_at >= 0 && k == abort_at + 1) begin
        n_checks++;
        if (bus.busy !== 1'b0 || bus.vec_o !== '0 || bus.pass !== 1'b0 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_state: got busy=%b vec=%0d pass=%b done=%b, want all 0",
                   bus.busy, bus.vec_o, bus.pass, bus.done);
        end
      end
      if (done_cyc >= 0) break;
      bus.start = (k == restart_at);
      bus.abort = (k == abort_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.expected = '0;
    f_tab = sop_table();
    #22;
    n_checks++;
    if ({bus.vec_o, bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_count, bus.first_fail} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vec=%0d busy=%b done=%b pass=%b tt=%h mm=%0d ff=%0d, want all 0",
               bus.vec_o, bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_count, bus.first_fail);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_and_check(input string name, input logic [NV-1:0] exp, input int restart_at);
    int dc;
    logic [NV-1:0] m_tt; logic [N:0] m_mm; logic [N-1:0] m_ff; logic m_ps;
    model(exp, f_tab, NV, m_tt, m_mm, m_ff, m_ps);
    do_sweep(exp, restart_at, -1, dc);
    n_checks++;
    if (dc !== SWEEP) begin
      n_fail++; $display("FAIL %s_done_cycle: got %0d, want %0d", name, dc, SWEEP);
    end
    n_checks++;
    if ({bus.truth_table, bus.mismatch_count, bus.first_fail, bus.pass} !== {m_tt, m_mm, m_ff, m_ps}) begin
      n_fail++;
      $display("FAIL %s_results: got tt=%h mm=%0d ff=%0d pass=%b, want tt=%h mm=%0d ff=%0d pass=%b",
               name, bus.truth_table, bus.mismatch_count, bus.first_fail, bus.pass, m_tt, m_mm, m_ff, m_ps);
    end
  endtask

  task automatic test_basic();
    f_tab = sop_table();
    run_and_check("match_27", 8'h27, -1);
    run_and_check("expect_25", 8'h25, -1);
    f_tab = 8'hFF;
    run_and_check("stuck_at_1", 8'h27, -1);
    f_tab = sop_table();
    run_and_check("all_fail_d8", 8'hD8, -1);
  endtask

  task automatic test_restart_ignored();
    f_tab = sop_table();
    run_and_check("restart_ignored", 8'h27, 5);
  endtask

  task automatic test_abort();
    int dc;
    logic [NV-1:0] m_tt; logic [N:0] m_mm; logic [N-1:0] m_ff; logic m_ps;
    f_tab = sop_table();
    // Abort sampled at edge 8: vectors 0..2 captured, vector 3's sample is dropped.
    model(8'h25, f_tab, 3, m_tt, m_mm, m_ff, m_ps);
    do_sweep(8'h25, -1, 7, dc);
    n_checks++;
    if (dc !== -1) begin
      n_fail++; $display("FAIL abort_no_done: done seen at cycle %0d, want none", dc);
    end
    n_checks++;
    if ({bus.truth_table, bus.mismatch_count} !== {m_tt, m_mm}) begin
      n_fail++;
      $display("FAIL abort_partial: got tt=%h mm=%0d, want tt=%h mm=%0d",
               bus.truth_table, bus.mismatch_count, m_tt, m_mm);
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.busy, bus.truth_table, bus.mismatch_count} !== {1'b0, m_tt, m_mm}) begin
      n_fail++;
      $display("FAIL abort_in_idle: got busy=%b tt=%h mm=%0d, want busy=0 tt=%h mm=%0d",
               bus.busy, bus.truth_table, bus.mismatch_count, m_tt, m_mm);
    end
  endtask

  task automatic test_reset_mid();
    f_tab = sop_table();
    bus.start = 1'b1; bus.expected = 8'h27;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.vec_o, bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_count, bus.first_fail} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got vec=%0d busy=%b tt=%h mm=%0d, want all 0",
               bus.vec_o, bus.busy, bus.truth_table, bus.mismatch_count);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_and_check("after_reset", 8'h27, -1);
  endtask

  task automatic test_back_to_back();
    int seen;
    logic [NV-1:0] m_tt; logic [N:0] m_mm; logic [N-1:0] m_ff; logic m_ps;
    f_tab = sop_table();
    run_and_check("b2b_first", 8'hD8, -1);
    // Still in the done cycle: this start must be accepted.
    bus.start = 1'b1; bus.expected = 8'h25;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.expected = 8'h00;
    n_checks++;
    if ({bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b pass=%b tt=%h mm=%0d, want busy=1 rest 0",
               bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_count);
    end
    seen = -1;
    for (int k = 1; k <= SWEEP + 8 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen = k;
    end
    model(8'h25, f_tab, NV, m_tt, m_mm, m_ff, m_ps);
    n_checks++;
    if (seen !== SWEEP || {bus.truth_table, bus.mismatch_count, bus.first_fail, bus.pass} !== {m_tt, m_mm, m_ff, m_ps}) begin
      n_fail++;
      $display("FAIL b2b_second: got done@%0d tt=%h mm=%0d ff=%0d pass=%b, want done@%0d tt=%h mm=%0d ff=%0d pass=%b",
               seen, bus.truth_table, bus.mismatch_count, bus.first_fail, bus.pass,
               SWEEP, m_tt, m_mm, m_ff, m_ps);
    end
  endtask

  task automatic test_random();
    logic [NV-1:0] exp;
    for (int r = 0; r < 12; r++) begin
      f_tab = NV'($urandom);
      exp   = (r % 3 == 0) ? f_tab : NV'($urandom);
      run_and_check($sformatf("random%0d", r), exp, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
